// File: rtl/power_frame_rx.sv
// Serial frame receiver for the chip-stack power results: deserialises, validates and queues records.
// Optional even-parity bit per frame is enabled by defining PARITY_CHECK_EN.
module power_frame_rx #(
  parameter int unsigned NUM_CHIPS  = 8,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned PWR_W      = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 t_clk,
  input  logic                 rst_n,
  input  logic                 data_in,
  input  logic                 clear,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [ID_W-1:0]      rec_chip_id,
  output logic [PWR_W-1:0]     rec_power_upper,
  output logic [PWR_W-1:0]     rec_power_lower,
  output logic                 frame_err,
  output logic                 dup_err,
  output logic                 overflow,
  output logic [NUM_CHIPS-1:0] seen_mask,
  output logic                 all_done
);

  localparam int unsigned DATA_W = ID_W + 2 * PWR_W;
  localparam int unsigned CNT_W  = $clog2(DATA_W);
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);

`ifdef PARITY_CHECK_EN
  typedef enum logic [2:0] {IDLE, DATA, PAR, STOP, RECOVER} state_t;
`else
  typedef enum logic [2:0] {IDLE, DATA, STOP, RECOVER} state_t;
`endif

  state_t              state, state_nx;
  logic                cnt_clr, shift_en, frame_end;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   shreg;
  logic                par_ok;
  logic [ID_W-1:0]     rx_id;
  logic                id_ok, frame_good, frame_bad;
  logic [NUM_CHIPS-1:0] id_hot;

  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                full, push, pop;
  logic [DATA_W-1:0]   head;

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (!data_in) begin
          state_nx = DATA;
          cnt_clr  = 1'b1;
        end
      end
      DATA: begin
        shift_en = 1'b1;
        if (cnt == CNT_W'(DATA_W - 1)) begin
`ifdef PARITY_CHECK_EN
          state_nx = PAR;
`else
          state_nx = STOP;
`endif
        end
      end
`ifdef PARITY_CHECK_EN
      PAR: state_nx = STOP;
`endif
      STOP: begin
        frame_end = 1'b1;
        state_nx  = data_in ? IDLE : RECOVER;
      end
      RECOVER: if (data_in) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (shift_en) begin
      cnt   <= cnt + 1'b1;
      shreg <= {shreg[DATA_W-2:0], data_in};
    end
  end

`ifdef PARITY_CHECK_EN
  logic par_bit;
  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n)             par_bit <= 1'b0;
    else if (state == PAR)  par_bit <= data_in;
  end
  assign par_ok = ~^{shreg, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  // The frame is judged in the STOP cycle, with data_in holding the stop bit.
  assign rx_id      = shreg[DATA_W-1 -: ID_W];
  assign id_ok      = 32'(rx_id) < NUM_CHIPS;
  assign frame_good = frame_end & data_in & par_ok & id_ok;
  assign frame_bad  = frame_end & ~(data_in & par_ok & id_ok);
  assign id_hot     = {{(NUM_CHIPS-1){1'b0}}, 1'b1} << rx_id;

  assign full = (count == (AW+1)'(FIFO_DEPTH));
  assign pop  = rec_valid & rec_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push = frame_good & (~full | pop);

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head            = mem[rd_ptr];
  assign rec_valid       = (count != '0);
  assign rec_chip_id     = head[DATA_W-1 -: ID_W];
  assign rec_power_upper = head[2*PWR_W-1 -: PWR_W];
  assign rec_power_lower = head[PWR_W-1:0];

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_mask <= '0;
      all_done  <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      dup_err   <= 1'b0;
    end else begin
      frame_err <= frame_bad;
      dup_err   <= push & (|(seen_mask & id_hot));
      all_done  <= clear ? 1'b0 : (&seen_mask);
      // clear wins over a same-cycle mask set; the record itself is still queued.
      if (clear) begin
        seen_mask <= '0;
        overflow  <= 1'b0;
      end else begin
        if (push)              seen_mask <= seen_mask | id_hot;
        if (frame_good & ~push) overflow  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_power_frame_rx.sv
// Randomised bench for power_frame_rx against a queue-based frame-level reference model.
module tb_power_frame_rx;

  localparam int NCH   = 8;
  localparam int DEPTH = 4;
`ifdef PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] id;
    logic [3:0] up;
    logic [3:0] lo;
  } rec_t;

  logic       t_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_in = 1'b1;
  logic       clear = 1'b0;
  logic       rec_ready = 1'b0;
  logic       rec_valid;
  logic [3:0] rec_chip_id, rec_power_upper, rec_power_lower;
  logic       frame_err, dup_err, overflow, all_done;
  logic [7:0] seen_mask;

  power_frame_rx #(.NUM_CHIPS(8), .ID_W(4), .PWR_W(4), .FIFO_DEPTH(4)) dut (
    .t_clk(t_clk), .rst_n(rst_n), .data_in(data_in), .clear(clear),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_chip_id(rec_chip_id),
    .rec_power_upper(rec_power_upper), .rec_power_lower(rec_power_lower),
    .frame_err(frame_err), .dup_err(dup_err), .overflow(overflow),
    .seen_mask(seen_mask), .all_done(all_done)
  );

  always #5 t_clk = ~t_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Reference model state: what the receiver should be showing right now.
  rec_t       q[$];
  logic [7:0] m_mask;
  logic       m_done, m_ovf, m_ferr, m_dup;
  bit         rand_ready = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("rec_valid", 32'(rec_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("rec_chip_id", 32'(rec_chip_id), 32'(q[0].id));
      check("rec_power_upper", 32'(rec_power_upper), 32'(q[0].up));
      check("rec_power_lower", 32'(rec_power_lower), 32'(q[0].lo));
    end
    check("frame_err", 32'(frame_err), 32'(m_ferr));
    check("dup_err", 32'(dup_err), 32'(m_dup));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("seen_mask", 32'(seen_mask), 32'(m_mask));
    check("all_done", 32'(all_done), 32'(m_done));
  endtask

  task automatic model_reset();
    q.delete();
    m_mask = '0; m_done = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0; m_dup = 1'b0;
  endtask

  // One line bit. is_stop marks the stop-bit cycle; ok says whether that frame is acceptable.
  task automatic tick(input logic din, input bit is_stop, input bit ok, input rec_t r);
    int size_b;
    bit pop, n_ferr, n_dup, n_done;
    data_in = din;
    if (rand_ready) rec_ready = ($urandom_range(0, 1) == 1);
    @(negedge t_clk);
    check_outputs();
    size_b = q.size();
    pop    = rec_ready && (size_b != 0);
    n_done = !clear && (m_mask == 8'hFF);
    n_ferr = is_stop && !ok;
    n_dup  = 1'b0;
    if (pop) void'(q.pop_front());
    if (is_stop && ok) begin
      if (size_b < DEPTH || pop) begin
        q.push_back(r);
        n_dup = m_mask[r.id[2:0]];
        m_mask[r.id[2:0]] = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (clear) begin
      m_mask = '0;
      m_ovf  = 1'b0;
    end
    @(posedge t_clk);
    #1;
    m_ferr = n_ferr;
    m_dup  = n_dup;
    m_done = n_done;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1'b1, 1'b0, 1'b0, '0);
    clear = 1'b0;
  endtask

  task automatic send_frame(input rec_t r, input bit stop_bit, input bit flip);
    logic [11:0] w;
    logic        par;
    bit          ok;
    int          k;
    w   = r;
    par = ^w;
    if (flip && PAR_EN) begin
      k = int'($urandom_range(0, 11));
      w = w ^ (12'd1 << k);
    end
    ok = stop_bit && (int'(r.id) < NCH) && !(flip && PAR_EN);
    tick(1'b0, 1'b0, 1'b0, '0);
    for (int i = 11; i >= 0; i--) tick(w[i], 1'b0, 1'b0, '0);
    if (PAR_EN) tick(par, 1'b0, 1'b0, '0);
    tick(stop_bit, 1'b1, ok, r);
  endtask

  task automatic do_reset(input int n);
    rst_n   = 1'b0;
    data_in = 1'b1;
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge t_clk);
      check_outputs();
      check("rst_chip_id", 32'(rec_chip_id), 32'd0);
      check("rst_power", 32'({rec_power_upper, rec_power_lower}), 32'd0);
      @(posedge t_clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  function automatic rec_t mk(input int id, input int up, input int lo);
    rec_t r;
    r.id = 4'(id); r.up = 4'(up); r.lo = 4'(lo);
    return r;
  endfunction

  initial begin
    rec_t r;
    model_reset();
    #1;
    do_reset(3);
    idle(2);

    // Single frame, immediate consumer
    rec_ready = 1'b1;
    send_frame(mk(3, 4'hA, 4'h5), 1'b1, 1'b0);
    idle(3);

    // Full sweep 7..0
    pulse_clear();
    for (int id = 7; id >= 0; id--) begin
      send_frame(mk(id, 15 - id, id + 2), 1'b1, 1'b0);
      idle(int'($urandom_range(0, 2)));
    end
    idle(3);

    // Error frames
    pulse_clear();
    send_frame(mk(2, 1, 1), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, '0);
    idle(1);
    send_frame(mk(2, 4, 6), 1'b1, 1'b0);
    idle(2);
    send_frame(mk(4'hB, 3, 3), 1'b1, 1'b0);
    idle(2);
    if (PAR_EN) begin
      send_frame(mk(6, 9, 12), 1'b1, 1'b1);
      idle(2);
    end

    // Back-pressure and overflow
    pulse_clear();
    rec_ready = 1'b0;
    for (int id = 0; id < 5; id++) begin
      send_frame(mk(id, id + 8, 7 - id), 1'b1, 1'b0);
      idle(1);
    end
    rec_ready = 1'b1;
    idle(6);

    // Duplicate and clear with FIFO retained
    pulse_clear();
    rec_ready = 1'b0;
    send_frame(mk(5, 1, 2), 1'b1, 1'b0);
    idle(1);
    send_frame(mk(5, 3, 4), 1'b1, 1'b0);
    idle(1);
    pulse_clear();
    idle(2);
    rec_ready = 1'b1;
    idle(4);

    // Randomised traffic with random back-pressure and occasional clear
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      r.id = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
      r.up = 4'($urandom_range(0, 15));
      r.lo = 4'($urandom_range(0, 15));
      send_frame(r, $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) pulse_clear();
      else idle(int'($urandom_range(1, 3)));
    end
    rand_ready = 1'b0;
    rec_ready  = 1'b1;
    idle(8);

    // Reset in the middle of a frame
    pulse_clear();
    tick(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, '0);
    do_reset(3);
    idle(2);
    send_frame(mk(1, 4'hC, 4'h3), 1'b1, 1'b0);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/power_frame_rx.md
Name: power_frame_rx

Overview:
- Downstream consumer of the serial `data_out` stream produced by the eight-chip stack top.
- Deserialises per-chip result frames (chip ID plus upper/lower power value) sampled on the stack clock.
- Validates each frame and buffers decoded records in a small FIFO with a valid/ready handshake.
- Keeps a per-chip presence mask; asserts `all_done` once every chip in the stack has reported.

Parameters:
- NUM_CHIPS, 8, number of chips in the stack; legal IDs are 0..NUM_CHIPS-1.
- ID_W, 4, chip ID width.
- PWR_W, 4, width of each power nibble (upper and lower).
- FIFO_DEPTH, 4, record FIFO entries; power of two, minimum 2.

Ports:
- t_clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  1  serial line from the stack `data_out`; idles high.
- clear  in  1  synchronous pulse; clears seen_mask, all_done and sticky flags; does not flush the FIFO.
- rec_valid  out  1  FIFO head record available.
- rec_ready  in  1  consumer accepts the head record when rec_valid=1.
- rec_chip_id  out  ID_W  head record chip ID.
- rec_power_upper  out  PWR_W  head record upper power value.
- rec_power_lower  out  PWR_W  head record lower power value.
- frame_err  out  1  one-cycle pulse on a bad stop bit, parity failure or out-of-range ID.
- dup_err  out  1  one-cycle pulse when an accepted ID is already set in seen_mask.
- overflow  out  1  sticky; a valid frame was dropped because the FIFO was full.
- seen_mask  out  NUM_CHIPS  bit i set once chip i has been accepted.
- all_done  out  1  high while seen_mask is all ones.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO empty.
- Frame format, one bit per t_clk:
  - start bit 0;
  - chip_id, MSB first;
  - power_upper, MSB first;
  - power_lower, MSB first;
  - [parity bit, only with PARITY_CHECK_EN];
  - stop bit 1.
- FSM states:
  - IDLE: data_in=0 goes to DATA and clears the bit counter.
  - DATA: shifts in ID_W+2*PWR_W bits, then goes to PAR (option enabled) or STOP.
  - PAR: samples the parity bit, then goes to STOP.
  - STOP: samples the stop bit, then goes to IDLE (stop=1) or RECOVER (stop=0).
  - RECOVER: waits for data_in=1, then goes to IDLE. This prevents a stuck-low line from re-triggering frames back to back.
- Frame check, in the STOP cycle:
  - stop=1, parity OK and ID<NUM_CHIPS: frame is valid.
  - Any failure: frame_err pulses the next cycle and the frame is discarded.
- Valid frame, in the cycle after STOP:
  - If the FIFO is not full: push the record and set seen_mask[id].
  - If seen_mask[id] was already 1: dup_err pulses and the record is still pushed.
  - If the FIFO is full: drop the record, set overflow, leave seen_mask unchanged.
- Latency: with the FIFO empty, rec_valid rises one cycle after the stop-bit sample cycle. Fields are stable while rec_valid=1 and rec_ready=0.
- FIFO:
  - Pop on rec_valid&rec_ready.
  - A simultaneous push and pop when full is allowed and is not an overflow.
  - A simultaneous push and pop when empty goes through the FIFO; there is no bypass.
  - Pointers wrap modulo FIFO_DEPTH.
- all_done is registered: it asserts the cycle after the last missing bit of seen_mask is set.
- clear vs. a same-cycle mask set: clear has priority; the set is lost and the record is still pushed.
- Reset mid-frame aborts the frame; no partial record is produced.

Optional Feature:
- Macro PARITY_CHECK_EN.
- Defined:
  - The frame carries an even-parity bit over all ID and power bits, so the total count of ones including the parity bit is even.
  - A mismatch raises frame_err and discards the frame.
- Undefined:
  - There is no PAR state or parity bit; the frame is start + ID_W+2*PWR_W data bits + stop.
  - A parity failure never contributes to frame_err.

Test Plan:
- Single frame: line sequence 0,0011,1010,0101,(parity 0),1 -> rec_valid one cycle after the stop sample; fields id=3, upper=0xA, lower=0x5; seen_mask=0x08.
- Full sweep: IDs 7..0, each with distinct power values; rec_ready=1 throughout -> eight records in order; all_done rises the cycle after ID 0 is accepted; seen_mask=0xFF.
- Errors:
  - Stop bit 0 on id=2 -> frame_err pulse, no record; FSM stays in RECOVER while the line is low, then accepts the next good frame.
  - ID 0xB -> frame_err, no record.
  - With PARITY_CHECK_EN, flip one data bit -> frame_err, no record.
- Back-pressure: rec_ready=0, send 5 valid frames (IDs 0..4) -> first 4 buffered; 5th dropped; overflow=1; seen_mask=0x0F. Then rec_ready=1 drains IDs 0..3 in order.
- Duplicate and clear: send id=5 twice -> two records, dup_err on the second. Pulse clear -> seen_mask=0, overflow=0; FIFO contents retained.
- Async reset: assert rst_n=0 mid-DATA for 3 cycles, then send a fresh frame -> outputs 0 during reset; only the fresh record appears.
